i2c_bus_arbiter: RTL and testbench
==================================

I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 16'd250, giving the bus-idle guard time between grants (5 us at 50 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 24'd5000000, giving the maximum grant hold time (100 ms).
REQ-003 The block SHALL have port CLOCK_50_B5B, input, 1 bit, the system clock.
REQ-004 The block SHALL have port RESET, input, 1 bit, the reset: synchronous, active-low.
REQ-005 The block SHALL have port req, input, 3 bits, the per-requester bus request (bit0 = adv7513_init, bit1 = adv7513_reg_read, bit2 = camera config).
REQ-006 The block SHALL have port scl_low_in, input, 3 bits, the per-requester request to pull SCL low.
REQ-007 The block SHALL have port sda_low_in, input, 3 bits, the per-requester request to pull SDA low.
REQ-008 The block SHALL have port grant, output, 3 bits, the one-hot grant.
REQ-009 The block SHALL have port grant_id, output, 2 bits, the encoded owner (2'd3 = none).
REQ-010 The block SHALL have port scl_oe, output, 1 bit; 1 = drive the SCL pad low, 0 = release the pad.
REQ-011 The block SHALL have port sda_oe, output, 1 bit; 1 = drive the SDA pad low, 0 = release the pad.
REQ-012 The block SHALL have port busy, output, 1 bit; it SHALL be high in every state other than S_IDLE.
REQ-013 The block SHALL have port timeout_err, output, 1 bit, a one-cycle pulse on grant timeout.

Function
REQ-014 The FSM SHALL have three states: S_IDLE, S_GRANT and S_GAP; all outputs SHALL be registered.
REQ-015 In S_IDLE with any eligible req bit set at cycle N, the FSM SHALL enter S_GRANT at N+1. At N+1, grant and grant_id SHALL select the winner, and busy SHALL be 1.
REQ-016 The winner SHALL be chosen round-robin: search starts at index (last_owner+1) mod 3, ascending with wrap; last_owner resets to 2, so bit0 wins first.
REQ-017 In S_GRANT, scl_oe SHALL equal scl_low_in[owner] and sda_oe SHALL equal sda_low_in[owner], each registered with one cycle latency. Drive-low requests from non-owners SHALL be ignored.
REQ-018 In S_GRANT, if req[owner] = 0 at cycle N, the FSM SHALL enter S_GAP at N+1 with grant = 0, grant_id = 3, scl_oe = 0 and sda_oe = 0.
REQ-019 The 24-bit hold counter SHALL clear on entry to S_GRANT and increment each cycle in S_GRANT.
REQ-020 When the hold counter equals TIMEOUT_CYCLES-1 while req[owner] is still 1, the FSM SHALL enter S_GAP, timeout_err SHALL pulse for 1 cycle, and the owner's lockout bit SHALL be set.
REQ-021 A requester with its lockout bit set SHALL be ineligible until its req bit is observed at 0, which clears that lockout bit.
REQ-022 If req drop and timeout occur in the same cycle, the block SHALL treat it as a normal release: no timeout_err and no lockout.
REQ-023 In S_GAP, the 16-bit gap counter SHALL count GAP_CYCLES cycles with the bus released, then the FSM SHALL return to S_IDLE. Requests seen during S_GAP SHALL be held pending, not lost.
REQ-024 If GAP_CYCLES = 0, S_GAP SHALL last exactly 1 cycle.
REQ-025 last_owner SHALL update on each grant; a re-request by the previous owner SHALL lose to any other eligible requester.
REQ-026 grant SHALL never have more than one bit set, and scl_oe and sda_oe SHALL be 0 whenever grant = 0.

Reset
REQ-027 While RESET = 0 at a clock edge, the block SHALL set state = S_IDLE, grant = 0, grant_id = 3, scl_oe = 0, sda_oe = 0, busy = 0, timeout_err = 0, lockout = 0, last_owner = 2, and both counters = 0.
REQ-028 A reset asserted mid-grant SHALL release the bus at the next edge, with no gap phase.

Verification
REQ-029 Single requester: req = 3'b001 after reset -> grant = 001 and grant_id = 0 one cycle later; scl_oe follows scl_low_in[0] with 1-cycle lag.
REQ-030 Contention: req = 3'b111 held, each requester dropping after 10 cycles -> grant order 001, 010, 100, 001, with 250 idle cycles between grants.
REQ-031 Isolation: owner = 1 while scl_low_in = 3'b101 and sda_low_in = 3'b001 -> scl_oe = 0 and sda_oe = 0.
REQ-032 Timeout: TIMEOUT_CYCLES = 100 and req[0] stuck at 1 -> timeout_err pulses at grant cycle 100; req[0] is then not regranted until it toggles low, while req[1] is granted after the gap.
REQ-033 Reset mid-grant: RESET = 0 during S_GRANT with scl_oe = 1 -> next edge gives scl_oe = 0, grant = 0, busy = 0; after RESET = 1 with req = 3'b011 -> bit0 is granted.
REQ-034 Boundary: req drop on the exact timeout cycle -> no timeout_err and no lockout.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner arbiter for a shared open-drain I2C bus: one requester at a time
// drives SCL/SDA low, with a released-bus guard gap between owners and a hold timeout.
module i2c_bus_arbiter #(
  parameter logic [15:0] GAP_CYCLES     = 16'd250,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
  input  logic       CLOCK_50_B5B,
  input  logic       RESET,
  input  logic [2:0] req,
  input  logic [2:0] scl_low_in,
  input  logic [2:0] sda_low_in,
  output logic [2:0] grant,
  output logic [1:0] grant_id,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  grant_reg, grant_next;
  logic [1:0]  grant_id_reg, grant_id_next;
  logic        scl_oe_reg, scl_oe_next;
  logic        sda_oe_reg, sda_oe_next;
  logic        busy_reg, busy_next;
  logic        timeout_err_reg, timeout_err_next;
  logic [2:0]  lockout_reg, lockout_next;
  logic [1:0]  last_owner_reg, last_owner_next;
  logic [23:0] hold_cnt_reg, hold_cnt_next;
  logic [15:0] gap_cnt_reg, gap_cnt_next;

  logic [2:0]  eligible;
  logic        win_valid;
  logic [1:0]  win_idx;
  logic        owner_req;
  logic        owner_scl;
  logic        owner_sda;
  logic        gap_done;

  function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  assign eligible = req & ~lockout_reg;
  // A zero-length gap still spends one cycle in S_GAP.
  assign gap_done = (GAP_CYCLES == 16'd0) || (gap_cnt_reg == GAP_CYCLES - 16'd1);

  // Search starts just past the previous owner, so a re-request by it loses to anyone else.
  always_comb begin
    logic [1:0] cand;
    win_valid = 1'b0;
    win_idx   = 2'd0;
    cand      = wrap_inc(last_owner_reg);
    for (int i = 0; i < 3; i++) begin
      if (!win_valid && eligible[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  always_comb begin
    owner_req = 1'b0;
    owner_scl = 1'b0;
    owner_sda = 1'b0;
    case (grant_id_reg)
      2'd0: begin
        owner_req = req[0];
        owner_scl = scl_low_in[0];
        owner_sda = sda_low_in[0];
      end
      2'd1: begin
        owner_req = req[1];
        owner_scl = scl_low_in[1];
        owner_sda = sda_low_in[1];
      end
      2'd2: begin
        owner_req = req[2];
        owner_scl = scl_low_in[2];
        owner_sda = sda_low_in[2];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    grant_id_next    = grant_id_reg;
    scl_oe_next      = 1'b0;
    sda_oe_next      = 1'b0;
    timeout_err_next = 1'b0;
    lockout_next     = lockout_reg & req;
    last_owner_next  = last_owner_reg;
    hold_cnt_next    = hold_cnt_reg;
    gap_cnt_next     = gap_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (win_valid) begin
          state_next      = S_GRANT;
          grant_next      = 3'b001 << win_idx;
          grant_id_next   = win_idx;
          last_owner_next = win_idx;
          hold_cnt_next   = 24'd0;
        end
      end
      S_GRANT: begin
        if (!owner_req || hold_cnt_reg == TIMEOUT_CYCLES - 24'd1) begin
          state_next    = S_GAP;
          grant_next    = 3'b000;
          grant_id_next = 2'd3;
          gap_cnt_next  = 16'd0;
          // A release on the timeout cycle itself wins over the timeout.
          if (owner_req) begin
            timeout_err_next = 1'b1;
            lockout_next     = lockout_next | grant_reg;
          end
        end else begin
          hold_cnt_next = hold_cnt_reg + 24'd1;
          scl_oe_next   = owner_scl;
          sda_oe_next   = owner_sda;
        end
      end
      S_GAP: begin
        if (gap_done) begin
          state_next = S_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 16'd1;
        end
      end
      default: begin
        state_next    = S_IDLE;
        grant_next    = 3'b000;
        grant_id_next = 2'd3;
      end
    endcase
    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge CLOCK_50_B5B) begin
    if (!RESET) begin
      state_reg       <= S_IDLE;
      grant_reg       <= 3'b000;
      grant_id_reg    <= 2'd3;
      scl_oe_reg      <= 1'b0;
      sda_oe_reg      <= 1'b0;
      busy_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
      lockout_reg     <= 3'b000;
      last_owner_reg  <= 2'd2;
      hold_cnt_reg    <= 24'd0;
      gap_cnt_reg     <= 16'd0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      grant_id_reg    <= grant_id_next;
      scl_oe_reg      <= scl_oe_next;
      sda_oe_reg      <= sda_oe_next;
      busy_reg        <= busy_next;
      timeout_err_reg <= timeout_err_next;
      lockout_reg     <= lockout_next;
      last_owner_reg  <= last_owner_next;
      hold_cnt_reg    <= hold_cnt_next;
      gap_cnt_reg     <= gap_cnt_next;
    end
  end

  assign grant       = grant_reg;
  assign grant_id    = grant_id_reg;
  assign scl_oe      = scl_oe_reg;
  assign sda_oe      = sda_oe_reg;
  assign busy        = busy_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench: stimulus queues each expected output change with its cycle stamp;
// the monitor pops and compares whenever the DUT output vector changes.
module tb_i2c_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] req;
  logic [2:0] scl_in;
  logic [2:0] sda_in;
  logic [2:0] grant;
  logic [1:0] grant_id;
  logic       scl_oe;
  logic       sda_oe;
  logic       busy;
  logic       timeout_err;

  typedef struct {
    int         cyc;
    logic [8:0] v;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  bit   mon_en = 1'b0;
  bit   check_end = 1'b0;
  bit   mon_started = 1'b0;
  bit   mon_done = 1'b0;
  logic [8:0] out_prev = '0;

  i2c_bus_arbiter #(
    .GAP_CYCLES    (16'd250),
    .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .CLOCK_50_B5B(clk),
    .RESET       (reset_n),
    .req         (req),
    .scl_low_in  (scl_in),
    .sda_low_in  (sda_in),
    .grant       (grant),
    .grant_id    (grant_id),
    .scl_oe      (scl_oe),
    .sda_oe      (sda_oe),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_at(input int dc, input logic [2:0] g, input logic [1:0] id,
                        input logic s, input logic d, input logic b, input logic t,
                        input string nm);
    exp_t e;
    e.cyc  = cyc + dc;
    e.v    = {g, id, s, d, b, t};
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic exp_gap(input int dc, input string nm);
    exp_at(dc, 3'b000, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, nm);
  endtask

  task automatic exp_idle(input int dc, input string nm);
    exp_at(dc, 3'b000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic exp_grant(input int dc, input logic [2:0] g, input logic [1:0] id,
                           input logic s, input logic d, input string nm);
    exp_at(dc, g, id, s, d, 1'b1, 1'b0, nm);
  endtask

  // Drop all requests now: gap next cycle, idle after 250 released cycles.
  task automatic release_all(input string nm);
    req    = 3'b000;
    scl_in = 3'b000;
    sda_in = 3'b000;
    exp_gap(1, {nm, "_gap"});
    exp_idle(251, {nm, "_idle"});
    tick(260);
  endtask

  always @(negedge clk) begin
    logic [8:0] out_now;
    exp_t e;
    if (mon_en) begin
      out_now = {grant, grant_id, scl_oe, sda_oe, busy, timeout_err};
      n_vec++;
      if ($countones(grant) > 1 || (grant == 3'b000 && (scl_oe || sda_oe))) begin
        n_miss++;
        $display("FAIL invariant @cyc %0d: grant=%b scl_oe=%b sda_oe=%b", cyc, grant, scl_oe, sda_oe);
      end
      if (!mon_started || out_now != out_prev) begin
        mon_started = 1'b1;
        n_vec++;
        if (q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_change: got %b @cyc %0d, required no change", out_now, cyc);
        end else begin
          e = q.pop_front();
          if (out_now !== e.v || cyc != e.cyc) begin
            n_miss++;
            $display("FAIL %s: got %b @cyc %0d, required %b @cyc %0d", e.name, out_now, cyc, e.v, e.cyc);
          end else begin
            $display("ok   %s: %b @cyc %0d", e.name, out_now, cyc);
          end
        end
      end
      out_prev = out_now;
    end
    if (check_end && !mon_done) begin
      while (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        n_miss++;
        $display("FAIL %s: got no change, required %b @cyc %0d", e.name, e.v, e.cyc);
      end
      mon_done = 1'b1;
    end
  end

  initial begin
    reset_n = 1'b0;
    req     = 3'b000;
    scl_in  = 3'b000;
    sda_in  = 3'b000;
    tick(3);
    exp_idle(0, "reset_state");
    mon_en  = 1'b1;
    reset_n = 1'b1;
    tick(2);

    // Single requester, owner pin following, non-owner pins ignored
    req = 3'b001;
    exp_grant(1, 3'b001, 2'd0, 1'b0, 1'b0, "a_grant0");
    tick(2); scl_in = 3'b001;
    exp_grant(1, 3'b001, 2'd0, 1'b1, 1'b0, "a_scl_follow");
    tick(2); scl_in = 3'b000; sda_in = 3'b001;
    exp_grant(1, 3'b001, 2'd0, 1'b0, 1'b1, "a_sda_follow");
    tick(2); scl_in = 3'b110; sda_in = 3'b110;
    exp_grant(1, 3'b001, 2'd0, 1'b0, 1'b0, "a_nonowner_ignored");
    tick(2);
    release_all("a");

    reset_n = 1'b0; tick(2); reset_n = 1'b1; tick(1);

    // Contention: all request, each owner drops after 10 cycles
    req = 3'b111;
    exp_grant(1, 3'b001, 2'd0, 1'b0, 1'b0, "b_grant0");
    tick(10); req = 3'b110;
    exp_gap(1, "b_gap0"); exp_idle(251, "b_idle0");
    exp_grant(252, 3'b010, 2'd1, 1'b0, 1'b0, "b_grant1");
    tick(262); req = 3'b100;
    exp_gap(1, "b_gap1"); exp_idle(251, "b_idle1");
    exp_grant(252, 3'b100, 2'd2, 1'b0, 1'b0, "b_grant2");
    tick(262); req = 3'b001;
    exp_gap(1, "b_gap2"); exp_idle(251, "b_idle2");
    exp_grant(252, 3'b001, 2'd0, 1'b0, 1'b0, "b_grant0_again");
    tick(262);
    release_all("b");

    // Previous owner 0 loses to 1; owner 1 isolated from others' drive-low
    req = 3'b011;
    exp_grant(1, 3'b010, 2'd1, 1'b0, 1'b0, "c_grant1_rr");
    tick(2); scl_in = 3'b101; sda_in = 3'b001;
    tick(4); scl_in = 3'b111;
    exp_grant(1, 3'b010, 2'd1, 1'b1, 1'b0, "c_scl_owner");
    tick(2); scl_in = 3'b000; sda_in = 3'b000;
    exp_grant(1, 3'b010, 2'd1, 1'b0, 1'b0, "c_scl_release");
    tick(2);
    release_all("c");

    // Timeout with req[0] stuck; lockout until req[0] toggles low
    req = 3'b001;
    exp_grant(1, 3'b001, 2'd0, 1'b0, 1'b0, "d_grant0");
    exp_at(101, 3'b000, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, "d_timeout_pulse");
    exp_gap(102, "d_timeout_end");
    tick(110); req = 3'b011;
    exp_idle(241, "d_idle");
    exp_grant(242, 3'b010, 2'd1, 1'b0, 1'b0, "d_grant1_while_0_locked");
    tick(252); req = 3'b001;
    exp_gap(1, "d_gap1"); exp_idle(251, "d_idle1");
    tick(270); req = 3'b000;
    tick(1); req = 3'b001;
    exp_grant(1, 3'b001, 2'd0, 1'b0, 1'b0, "d_regrant_after_toggle");
    tick(5);
    release_all("d");

    // Release on the exact timeout cycle is a normal release
    req = 3'b001;
    exp_grant(1, 3'b001, 2'd0, 1'b0, 1'b0, "e_grant0");
    tick(100); req = 3'b000;
    exp_gap(1, "e_drop_at_timeout"); exp_idle(251, "e_idle");
    tick(260); req = 3'b001;
    exp_grant(1, 3'b001, 2'd0, 1'b0, 1'b0, "e_regrant");
    tick(5);
    release_all("e");

    // Reset mid-grant releases immediately; bit0 wins afterwards
    req = 3'b010;
    exp_grant(1, 3'b010, 2'd1, 1'b0, 1'b0, "f_grant1");
    tick(2); scl_in = 3'b010;
    exp_grant(1, 3'b010, 2'd1, 1'b1, 1'b0, "f_scl_low");
    tick(2); reset_n = 1'b0;
    exp_idle(1, "f_reset_release");
    tick(2); reset_n = 1'b1; req = 3'b011;
    exp_grant(1, 3'b001, 2'd0, 1'b0, 1'b0, "f_grant0_after_reset");
    tick(3);
    release_all("f");

    check_end = 1'b1;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
